shift_register_loader: RTL
==========================

// Module: shift_register_loader
// PURPOSE
//  Sequencer in front of the 8-bit serial-in shift_register. Accepts parallel words over valid/ready and serializes them MSB-first onto the register's data/shift_enable pins.
//  Issues register clears and pulses done when the register holds the word. Sits between a host/config master and one shift_register instance.
// PARAMETERS
//  WIDTH              8  shift register length / word width (>=2)
//  CLEAR_BEFORE_LOAD  0  1: every accepted word is preceded by one sr_reset cycle
// PORTS
//  clk              in   1      single clock, rising edge
//  reset            in   1      asynchronous, active-high
//  in_valid         in   1      host word valid
//  in_ready         out  1      controller can accept (combinational, see below)
//  in_data          in   WIDTH  word to load
//  clr_req          in   1      level request to clear the shift register
//  sr_reset         out  1      drives shift_register.reset
//  sr_data          out  1      drives shift_register.data
//  sr_shift_enable  out  1      drives shift_register.shift_enable
//  sr_stored_data   in   WIDTH  readback of shift_register.stored_data
//  busy             out  1      high in any state except IDLE
//  done             out  1      one-cycle pulse: word fully loaded
//  mismatch         out  1      readback error flag (only with macro, see CONFIGURATION)
// BEHAVIOUR
//  Register model: shift_enable=1 at a rising edge -> stored <= {stored[WIDTH-2:0], data}.
//  States: IDLE, CLEAR, SHIFT, CHECK. sr_* outputs, busy, done are registered.
//  Reset (async): state=IDLE, sr_reset=1, sr_data=0, sr_shift_enable=0, done=0, busy=0, mismatch=0, bit_cnt=0.
//   sr_reset drops to 0 at the first clk edge after reset release.
//  in_ready = (state==IDLE) && !clr_req. Accept = in_valid && in_ready at edge E0; in_data latched.
//  IDLE: clr_req -> CLEAR (priority over in_valid). Accept -> SHIFT (or CLEAR first if CLEAR_BEFORE_LOAD).
//  CLEAR: exactly one cycle, sr_reset=1, sr_shift_enable=0; then SHIFT if a word is pending, else IDLE.
//  SHIFT: WIDTH cycles; sr_shift_enable=1, sr_data=word[WIDTH-1-k] in the k-th cycle. bit_cnt counts WIDTH-1 down to 0.
//  CHECK: one cycle, sr_shift_enable=0, done=1, then IDLE. sr_stored_data==word holds in this cycle.
//  Latency, accept to done: WIDTH+1 cycles (WIDTH+2 with CLEAR_BEFORE_LOAD). Max throughput is one word per WIDTH+2 cycles.
//  clr_req outside IDLE: ignored until return to IDLE; a held level is then serviced before the next accept.
//  Back-to-back: a word presented during CHECK is not accepted, because in_ready=0 there. It is accepted in the following IDLE cycle.
//  Async reset mid-SHIFT: the word is dropped, no done pulse, and the sequence restarts from the reset values.
//  in_data changing after accept has no effect.
// CONFIGURATION
//  SHIFT_REGISTER_LOADER_READBACK_EN defined:
//   - in CHECK, mismatch <= (sr_stored_data != word).
//   - mismatch is sticky until the next accept or reset.
//  Not defined: mismatch is tied to 0 and there is no comparator logic.
// STRUCTURE
//  Package shift_register_loader_pkg:
//   - state typedef (IDLE=0, CLEAR=1, SHIFT=2, CHECK=3)
//   - DEFAULT_WIDTH constant
//   - function cnt_w(width) = $clog2(width)
//  Sub-module shift_register_loader_piso: word holding register, bit_cnt and MSB-select mux, with load/step/last outputs. The FSM stays in the top module.
// TESTING (bench instantiates loader + shift_register, clk period 10)
//  1 Reset release -> sr_reset=1 for the first cycle, then 0; in_ready=1, busy=0, sr_stored_data=8'h00.
//  2 Accept 8'hA5 -> 8 cycles with sr_shift_enable=1, sr_data=1,0,1,0,0,1,0,1.
//    done pulses 9 cycles after accept with sr_stored_data=8'hA5.
//  3 clr_req and in_valid both high in IDLE -> one CLEAR cycle, in_ready=0.
//    Then 8'h3C is accepted, and done is seen with stored=8'h3C.
//  4 clr_req raised mid-SHIFT of 8'hFF -> done with stored=8'hFF, then CLEAR, then stored=8'h00.
//  5 Reset asserted in the 4th SHIFT cycle of 8'h81 -> outputs return to reset values at once, no done.
//    Next load of 8'h01 -> stored=8'h01.
//  6 READBACK_EN: force bit0 of sr_stored_data to 0 during a load of 8'h01 -> mismatch=1 after CHECK.
//    mismatch stays 1 until the next accept.

Source files
------------

// File: rtl/shift_register_loader_pkg.sv
// Shared types and constants for the shift_register_loader sequencer.
// State encodings are plain logic constants so older code can compare against them directly.
package shift_register_loader_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t CLEAR = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t CHECK = 2'd3;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_register_loader_piso.sv
// Word holding register plus bit counter; presents the next bit to drive, MSB first.
// next_bit is the value sr_data should take at the coming edge (start or step).
module shift_register_loader_piso
  import shift_register_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             step,
  output logic [WIDTH-1:0] word,
  output logic             next_bit,
  output logic             last
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_m1;

  assign cnt_m1 = bit_cnt - 1'b1;
  assign last   = (bit_cnt == '0);

  // NOTE: a single holding register, not a memory array, so resetting it is cheap and keeps
  // the readback comparison deterministic after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else begin
      if (load) word <= din;
      if (start)     bit_cnt <= CW'(WIDTH - 1);
      else if (step) bit_cnt <= cnt_m1;
    end
  end

  // NOTE: default assignment first so the mux never infers a latch.
  always_comb begin
    next_bit = word[cnt_m1];
    if (start) next_bit = load ? din[WIDTH-1] : word[WIDTH-1];
  end

endmodule

// File: rtl/shift_register_loader.sv
// Sequencer serializing parallel words MSB-first into an external serial-in shift register.
// Optional readback compare: define SHIFT_REGISTER_LOADER_READBACK_EN to enable the mismatch flag.
module shift_register_loader
  import shift_register_loader_pkg::*;
#(
  parameter int WIDTH             = DEFAULT_WIDTH,
  parameter bit CLEAR_BEFORE_LOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_req,
  output logic             sr_reset,
  output logic             sr_data,
  output logic             sr_shift_enable,
  input  logic [WIDTH-1:0] sr_stored_data,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  state_t           state;
  state_t           next_state;
  logic             pending;
  logic             accept;
  logic             start;
  logic             step;
  logic             next_bit;
  logic             last;
  logic [WIDTH-1:0] word;

  assign in_ready = (state == IDLE) && !clr_req;
  assign accept   = in_valid && in_ready;
  assign start    = (accept && !CLEAR_BEFORE_LOAD) || ((state == CLEAR) && pending);
  assign step     = (state == SHIFT) && !last;

  shift_register_loader_piso #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .din      (in_data),
    .start    (start),
    .step     (step),
    .word     (word),
    .next_bit (next_bit),
    .last     (last)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clr_req)       next_state = CLEAR;
        else if (in_valid) next_state = CLEAR_BEFORE_LOAD ? CLEAR : SHIFT;
      end
      CLEAR:   next_state = pending ? SHIFT : IDLE;
      SHIFT:   if (last) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All sr_* pins and status flags are registered from next_state, so they line up with the state.
  // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      sr_reset        <= 1'b1;
      sr_data         <= 1'b0;
      sr_shift_enable <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= next_state;
      sr_reset        <= (next_state == CLEAR);
      sr_shift_enable <= (next_state == SHIFT);
      sr_data         <= (next_state == SHIFT) ? next_bit : 1'b0;
      busy            <= (next_state != IDLE);
      done            <= (next_state == CHECK);
      if (accept)              pending <= CLEAR_BEFORE_LOAD;
      else if (state == CLEAR) pending <= 1'b0;
    end
  end

`ifdef SHIFT_REGISTER_LOADER_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               mismatch <= 1'b0;
    else if (accept)         mismatch <= 1'b0;
    else if (state == CHECK) mismatch <= (sr_stored_data != word);
  end
`else
  logic unused_readback;
  assign unused_readback = ^{sr_stored_data, word};
  assign mismatch        = 1'b0;
`endif

endmodule
